// File: rtl/afifo_pkg.sv
// Shared types and Gray-code helpers for the asynchronous FIFO pointer handlers.
// The helpers work on 32-bit zero-extended values, so they serve any pointer width up to 31 bits.
package afifo_pkg;

  localparam int unsigned DefPtrWidth  = 3;
  localparam int unsigned DefDataWidth = 8;

  typedef logic [DefPtrWidth:0] ptr_t;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/rd_fwft_stage.sv
// First-word-fall-through output stage: head register plus one skid slot behind the
// synchronous-read memory, which returns data one cycle after the fetch.
module rd_fwft_stage
  import afifo_pkg::*;
#(
  parameter int unsigned Data_Width = DefDataWidth
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  pop,
  input  logic                  in_valid,
  input  logic [Data_Width-1:0] in_data,
  output logic                  rvalid,
  output logic [Data_Width-1:0] rdata,
  output logic [1:0]            occ
);

  logic                  rvalid_q, rvalid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic [Data_Width-1:0] rdata_q, rdata_d;
  logic [Data_Width-1:0] skid_q, skid_d;

  // The skid holds the older word, so it always drains into the head first.
  // The fetch throttle upstream guarantees the skid is free whenever it is loaded.
  always_comb begin
    rvalid_d     = rvalid_q;
    rdata_d      = rdata_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (pop || !rvalid_q) begin
      if (skid_valid_q) begin
        rvalid_d     = 1'b1;
        rdata_d      = skid_q;
        skid_valid_d = in_valid;
        if (in_valid) skid_d = in_data;
      end else if (in_valid) begin
        rvalid_d = 1'b1;
        rdata_d  = in_data;
      end else begin
        rvalid_d = 1'b0;
      end
    end else if (in_valid) begin
      skid_valid_d = 1'b1;
      skid_d       = in_data;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rvalid_q     <= 1'b0;
      skid_valid_q <= 1'b0;
      rdata_q      <= '0;
      skid_q       <= '0;
    end else begin
      rvalid_q     <= rvalid_d;
      skid_valid_q <= skid_valid_d;
      rdata_q      <= rdata_d;
      skid_q       <= skid_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
  assign occ    = {1'b0, rvalid_q} + {1'b0, skid_valid_q} + {1'b0, in_valid};

endmodule

// File: rtl/rptr_fwft_handler.sv
// Read-domain pointer/flag controller for the async FIFO with a FWFT output stage,
// fill level and almost-empty status.
module rptr_fwft_handler
  import afifo_pkg::*;
#(
  parameter int unsigned Ptr_Width  = DefPtrWidth,
  parameter int unsigned Data_Width = DefDataWidth,
  parameter int unsigned AE_Thresh  = 1
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  r_en,
  input  logic [Ptr_Width:0]    g_wptr_sync,
  input  logic [Data_Width-1:0] mem_rdata,
  output logic                  mem_ren,
  output logic [Ptr_Width:0]    b_rptr,
  output logic [Ptr_Width:0]    g_rptr,
  output logic [Data_Width-1:0] rdata,
  output logic                  rvalid,
  output logic                  empty,
  output logic                  almost_empty,
  output logic [Ptr_Width:0]    rlevel,
  output logic                  r_underflow
);

  localparam int unsigned PW = Ptr_Width + 1;

  logic [Ptr_Width:0] b_rptr_q, b_rptr_d;
  logic [Ptr_Width:0] g_rptr_q, g_rptr_d;
  logic [Ptr_Width:0] level_q, level_d;
  logic [Ptr_Width:0] wbin;
  logic               mem_empty_q, mem_empty_d;
  logic               inflight_q;
  logic               ae_q, ae_d;
  logic               underflow_q, underflow_d;
  logic               pop, fetch;
  logic [1:0]         occ;
  logic [31:0]        g32, w32;
  logic               unused_hi;

  always_comb begin
    pop         = r_en & rvalid;
    underflow_d = r_en & ~rvalid;
    // Keep at most two words owned by the output side (head + skid incl. in-flight).
    fetch       = !mem_empty_q && ((occ - {1'b0, pop}) < 2'd2);
    b_rptr_d    = b_rptr_q + PW'(fetch);
    g32         = bin2gray(32'(b_rptr_d));
    g_rptr_d    = g32[Ptr_Width:0];
    w32         = gray2bin(32'(g_wptr_sync));
    wbin        = w32[Ptr_Width:0];
    mem_empty_d = (g_rptr_d == g_wptr_sync);
    // Unfetched memory words plus next-cycle output-side occupancy, modulo pointer range.
    level_d     = wbin - b_rptr_d + PW'(occ) - PW'(pop) + PW'(fetch);
    ae_d        = (32'(level_d) <= AE_Thresh);
  end

  assign unused_hi = ^{g32[31:PW], w32[31:PW]};

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      b_rptr_q    <= '0;
      g_rptr_q    <= '0;
      mem_empty_q <= 1'b1;
      inflight_q  <= 1'b0;
      level_q     <= '0;
      ae_q        <= 1'b1;
      underflow_q <= 1'b0;
    end else begin
      b_rptr_q    <= b_rptr_d;
      g_rptr_q    <= g_rptr_d;
      mem_empty_q <= mem_empty_d;
      inflight_q  <= fetch;
      level_q     <= level_d;
      ae_q        <= ae_d;
      underflow_q <= underflow_d;
    end
  end

  rd_fwft_stage #(
    .Data_Width(Data_Width)
  ) u_fwft (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .pop     (pop),
    .in_valid(inflight_q),
    .in_data (mem_rdata),
    .rvalid  (rvalid),
    .rdata   (rdata),
    .occ     (occ)
  );

  assign mem_ren      = fetch;
  assign b_rptr       = b_rptr_q;
  assign g_rptr       = g_rptr_q;
  assign empty        = ~rvalid;
  assign almost_empty = ae_q;
  assign rlevel       = level_q;
  assign r_underflow  = underflow_q;

endmodule

// File: tb/tb_rptr_fwft_handler.sv
// Scoreboard bench for rptr_fwft_handler: a write-side model fills a small memory,
// expected words are queued at write time and a negedge monitor checks every pop.
module tb_rptr_fwft_handler;

  logic       rclk = 1'b0;
  logic       rrst_n;
  logic       r_en;
  logic [3:0] wptr;
  logic [3:0] g_wptr_sync;
  logic [7:0] mem_rdata = 8'h00;
  logic       mem_ren;
  logic [3:0] b_rptr, g_rptr, rlevel;
  logic [7:0] rdata;
  logic       rvalid, empty, almost_empty, r_underflow;

  logic [7:0] mem [8];
  logic [7:0] exp_q [$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] prev_g, prev_b;
  logic       prev_ok = 1'b0;
  logic       saw_wrap = 1'b0;

  always #5 rclk = ~rclk;

  assign g_wptr_sync = wptr ^ (wptr >> 1);

  always @(posedge rclk) begin
    if (mem_ren) mem_rdata <= mem[b_rptr[2:0]];
  end

  rptr_fwft_handler dut (
    .rclk        (rclk),
    .rrst_n      (rrst_n),
    .r_en        (r_en),
    .g_wptr_sync (g_wptr_sync),
    .mem_rdata   (mem_rdata),
    .mem_ren     (mem_ren),
    .b_rptr      (b_rptr),
    .g_rptr      (g_rptr),
    .rdata       (rdata),
    .rvalid      (rvalid),
    .empty       (empty),
    .almost_empty(almost_empty),
    .rlevel      (rlevel),
    .r_underflow (r_underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  // Monitor: pops are compared against the scoreboard; Gray pointer steps are checked.
  always @(negedge rclk) begin
    if (!rrst_n) begin
      prev_ok = 1'b0;
    end else begin
      if (r_en && rvalid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pop: got 0x%0h, expected no pop", rdata);
        end else begin
          chk("pop_data", {24'h0, rdata}, {24'h0, exp_q.pop_front()});
        end
      end
      if (prev_ok && g_rptr != prev_g) begin
        chk("gray_one_bit_step", $countones(g_rptr ^ prev_g), 1);
        chk("gray_matches_bin", {28'h0, g_rptr}, {28'h0, b_rptr ^ (b_rptr >> 1)});
      end
      if (prev_ok && prev_b == 4'd15 && b_rptr == 4'd0) saw_wrap = 1'b1;
      prev_g  = g_rptr;
      prev_b  = b_rptr;
      prev_ok = 1'b1;
    end
  end

  initial begin
    int lat, n, gaps, written;
    logic flag;
    rrst_n = 1'b0;
    r_en   = 1'b0;
    wptr   = 4'd0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;

    // Reset state
    repeat (3) tick();
    chk("rst_rvalid", {31'h0, rvalid}, 0);
    chk("rst_empty", {31'h0, empty}, 1);
    chk("rst_almost_empty", {31'h0, almost_empty}, 1);
    chk("rst_b_rptr", {28'h0, b_rptr}, 0);
    chk("rst_g_rptr", {28'h0, g_rptr}, 0);
    chk("rst_rlevel", {28'h0, rlevel}, 0);
    chk("rst_rdata", {24'h0, rdata}, 0);
    rrst_n = 1'b1;
    flag = 1'b0;
    repeat (4) begin
      tick();
      if (mem_ren) flag = 1'b1;
    end
    chk("idle_no_mem_ren", {31'h0, flag}, 0);

    // Single word: visible two edges after mem_empty samples it, i.e. third edge
    mem[0] = 8'hA5;
    wptr   = 4'd1;
    lat    = 0;
    while (!rvalid && lat < 10) begin
      tick();
      lat++;
    end
    chk("first_word_latency", lat, 3);
    chk("first_word_rdata", {24'h0, rdata}, 32'hA5);
    chk("first_word_b_rptr", {28'h0, b_rptr}, 1);
    chk("first_word_rlevel", {28'h0, rlevel}, 1);
    chk("first_word_almost_empty", {31'h0, almost_empty}, 1);
    chk("first_word_empty", {31'h0, empty}, 0);
    exp_q.push_back(8'hA5);
    r_en = 1'b1;
    tick();
    r_en = 1'b0;
    chk("after_pop_rvalid", {31'h0, rvalid}, 0);
    chk("after_pop_rlevel", {28'h0, rlevel}, 0);

    // Fill 8 words with output stage held full
    rrst_n = 1'b0;
    wptr   = 4'd0;
    tick();
    rrst_n = 1'b1;
    for (int i = 0; i < 8; i++) mem[i] = 8'(i);
    wptr = 4'd8;
    repeat (6) tick();
    chk("full_rlevel", {28'h0, rlevel}, 8);
    chk("full_b_rptr", {28'h0, b_rptr}, 2);
    chk("full_rvalid", {31'h0, rvalid}, 1);
    chk("full_almost_empty", {31'h0, almost_empty}, 0);
    flag = 1'b0;
    repeat (3) begin
      if (mem_ren) flag = 1'b1;
      tick();
    end
    chk("full_no_mem_ren", {31'h0, flag}, 0);
    chk("full_rlevel_held", {28'h0, rlevel}, 8);

    // Drain at one pop per cycle
    for (int i = 0; i < 8; i++) exp_q.push_back(8'(i));
    r_en = 1'b1;
    gaps = 0;
    for (int i = 0; i < 8; i++) begin
      if (!rvalid) gaps++;
      tick();
    end
    chk("drain_no_gaps", gaps, 0);
    chk("drain_all_popped", exp_q.size(), 0);
    chk("drain_empty", {31'h0, empty}, 1);

    // Underflow with r_en held while empty
    tick();
    chk("underflow_pulse", {31'h0, r_underflow}, 1);
    r_en = 1'b0;
    tick();
    chk("underflow_cleared", {31'h0, r_underflow}, 0);
    chk("underflow_b_rptr", {28'h0, b_rptr}, 8);
    chk("underflow_g_rptr", {28'h0, g_rptr}, 32'hC);

    // Stream 20 words across the pointer wrap
    r_en    = 1'b1;
    written = 0;
    n       = 0;
    while ((written < 20 || exp_q.size() != 0) && n < 300) begin
      if (written < 20 && 4'(wptr - b_rptr) < 4'd8) begin
        mem[wptr[2:0]] = 8'(8'h40 + written);
        exp_q.push_back(8'(8'h40 + written));
        wptr = wptr + 4'd1;
        written++;
      end
      tick();
      n++;
    end
    chk("wrap_finished_in_budget", {31'h0, n < 300}, 1);
    chk("wrap_seen", {31'h0, saw_wrap}, 1);
    chk("wrap_b_rptr", {28'h0, b_rptr}, 12);
    chk("wrap_g_rptr", {28'h0, g_rptr}, 32'hA);

    // Asynchronous reset in the middle of a stream
    for (int i = 0; i < 3; i++) begin
      mem[wptr[2:0]] = 8'(8'h5A + i);
      exp_q.push_back(8'(8'h5A + i));
      wptr = wptr + 4'd1;
    end
    repeat (4) tick();
    #2;
    rrst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_rvalid", {31'h0, rvalid}, 0);
    chk("arst_rdata", {24'h0, rdata}, 0);
    chk("arst_b_rptr", {28'h0, b_rptr}, 0);
    chk("arst_g_rptr", {28'h0, g_rptr}, 0);
    chk("arst_rlevel", {28'h0, rlevel}, 0);
    chk("arst_almost_empty", {31'h0, almost_empty}, 1);
    chk("arst_underflow", {31'h0, r_underflow}, 0);
    r_en = 1'b0;
    wptr = 4'd0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
